// File: rtl/vga_timing.sv
// Raster timing generator: pixel/line counters advanced on pix_en strobes,
// with sync, data-enable and position outputs registered from the next count.
module vga_timing #(
    parameter int   H_VISIBLE = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] hcount,
    output logic [9:0] vcount
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing: line or frame total exceeds 10-bit counter range");
    end

    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    // Band edges get an extra bit: a sync band may end exactly at 1024.
    localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
    localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
    localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0]  hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic [10:0] h_ext, v_ext;

    // Next position on a strobe, and outputs decoded from that next position.
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end
        h_ext   = {1'b0, hcount_d};
        v_ext   = {1'b0, vcount_d};
        de_d    = (h_ext < H_VIS) && (v_ext < V_VIS);
        hsync_d = ((h_ext >= HS_BEG) && (h_ext < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d = ((v_ext >= VS_BEG) && (v_ext < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    end

    // Position and timing registers; reset parks at (0,0) with syncs inactive.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
            de_q     <= 1'b0;
            hsync_q  <= ~HSYNC_POL;
            vsync_q  <= ~VSYNC_POL;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            de_q     <= de_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
        end
    end

    assign hcount = hcount_q;
    assign vcount = vcount_q;
    assign de     = de_q;
    assign hsync  = hsync_q;
    assign vsync  = vsync_q;

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: a default 640x480 instance and a
// small-raster instance (active-high syncs) share random pix_en/rst stimulus.
module tb_vga_timing;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pix_en = 1'b0;

    always #5 clk = ~clk;

    logic       hs_a, vs_a, de_a;
    logic [9:0] hc_a, vc_a;
    logic       hs_b, vs_b, de_b;
    logic [9:0] hc_b, vc_b;

    vga_timing u_a (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .hsync(hs_a), .vsync(vs_a), .de(de_a),
        .hcount(hc_a), .vcount(vc_a)
    );

    vga_timing #(
        .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
        .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(4),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) u_b (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .hsync(hs_b), .vsync(vs_b), .de(de_b),
        .hcount(hc_b), .vcount(vc_b)
    );

    typedef struct packed {
        logic [9:0] hc;
        logic [9:0] vc;
        logic       de;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int   checks = 0;
    int   failures = 0;
    // Linear raster index: strobes since frame start.
    int   pos_a = 0;
    int   pos_b = 0;

    localparam int FRAME_A = 800 * 525;
    localparam int FRAME_B = 32 * 20;

    function automatic exp_t ref_out(int pos, int hv, int hf, int hsw, int hb,
                                     int vv, int vf, int vsw, bit hp, bit vp);
        exp_t e;
        int ht = hv + hf + hsw + hb;
        int h = pos % ht;
        int v = pos / ht;
        e.hc = 10'(h);
        e.vc = 10'(v);
        e.de = (h < hv) && (v < vv);
        e.hs = (h >= hv + hf && h < hv + hf + hsw) ? hp : !hp;
        e.vs = (v >= vv + vf && v < vv + vf + vsw) ? vp : !vp;
        return e;
    endfunction

    function automatic exp_t rst_out(bit hp, bit vp);
        exp_t e;
        e.hc = '0;
        e.vc = '0;
        e.de = 1'b0;
        e.hs = !hp;
        e.vs = !vp;
        return e;
    endfunction

    task automatic step(input bit r, input bit p);
        @(negedge clk);
        rst = r;
        pix_en = p;
        if (!r) begin
            pos_a = 0;
            pos_b = 0;
            q_a.push_back(rst_out(1'b0, 1'b0));
            q_b.push_back(rst_out(1'b1, 1'b1));
        end else begin
            if (p) begin
                pos_a = (pos_a + 1) % FRAME_A;
                pos_b = (pos_b + 1) % FRAME_B;
            end
            q_a.push_back(ref_out(pos_a, 640, 16, 96, 48, 480, 10, 2, 1'b0, 1'b0));
            q_b.push_back(ref_out(pos_b, 16, 4, 6, 6, 12, 2, 2, 1'b1, 1'b1));
        end
    endtask

    task automatic check(input string name, input exp_t act, input exp_t e);
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL %s got hc=%0d vc=%0d de=%0b hs=%0b vs=%0b want hc=%0d vc=%0d de=%0b hs=%0b vs=%0b",
                     name, act.hc, act.vc, act.de, act.hs, act.vs,
                     e.hc, e.vc, e.de, e.hs, e.vs);
        end
    endtask

    // Monitor: one expected entry per issued edge, compared just after it.
    always @(posedge clk) begin
        #1;
        if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            check("vga_640x480", {hc_a, vc_a, de_a, hs_a, vs_a}, ea);
        end
        if (q_b.size() > 0) begin
            eb = q_b.pop_front();
            check("vga_small", {hc_b, vc_b, de_b, hs_b, vs_b}, eb);
        end
    end

    initial begin
        // Reset held with pix_en toggling.
        for (int i = 0; i < 5; i++) step(1'b0, i[0]);
        // Strobe every other clock across the first full line and beyond.
        for (int i = 0; i < 1700; i++) step(1'b1, ~i[0]);
        // Random strobes over many lines / many small frames.
        for (int i = 0; i < 40000; i++) step(1'b1, $urandom_range(0, 3) != 0);
        // Reset landing mid-frame on the small raster (h=20, v=8).
        for (int i = 0; i < 2000 && pos_b != 8 * 32 + 20; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) step(1'b1, $urandom_range(0, 1) != 0);
        // Reset at a random point, then resume.
        step(1'b0, 1'b1);
        for (int i = 0; i < 1500; i++) step(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d want pending=0", q_a.size() + q_b.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
